adder_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined add/sub unit for the NPC execute path; successor of the single-cycle adder.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/adder_slice.sv | 19 +
 rtl/adder_pipe.sv | 151 +++++++++++++++
 tb/tb_adder_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : execute-stage op codes shared by the decoder and adder_pipe    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADDW = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUBW = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd5;

  // Ops that add the inverted second operand plus one.
  function automatic logic alu_op_is_sub(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SUB) || (op == ALU_SUBW) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_slice : W-bit adder with carry in/out, one half of the pipelined add |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adder_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_pipe : 2-stage carry-split add/sub/slt unit with valid/ready ports |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int TAG_W    = 5,
  parameter int WORD_OPS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]    in_src1,
  input  logic [WIDTH-1:0]    in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_carry,
  output logic                out_ovf,
  output logic                out_zero
);

  localparam int c_half = WIDTH / 2;

  // Stage 1: low-half sum and raw high-half operands
  logic                r_s1_valid;
  logic [ALU_OP_W-1:0] r_s1_op;
  logic [TAG_W-1:0]    r_s1_tag;
  logic [c_half-1:0]   r_s1_hi_a;
  logic [c_half-1:0]   r_s1_hi_b;
  logic [c_half-1:0]   r_s1_lo_sum;
  logic                r_s1_lo_carry;

  // Stage 2 doubles as the output register
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_result;
  logic [TAG_W-1:0]    r_out_tag;
  logic                r_out_carry;
  logic                r_out_ovf;
  logic                r_out_zero;

  logic                w_sub;
  logic [WIDTH-1:0]    w_b_eff;
  logic [c_half-1:0]   w_lo_sum;
  logic                w_lo_carry;
  logic [c_half-1:0]   w_hi_sum;
  logic                w_carry;
  logic [WIDTH-1:0]    w_full;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_result;
  logic                w_advance;
  logic                w_s1_load;

  assign w_sub   = alu_op_is_sub(in_op);
  assign w_b_eff = w_sub ? ~in_src2 : in_src2;

  adder_slice #(.W(c_half)) u_lo_slice (
    .a    (in_src1[c_half-1:0]),
    .b    (w_b_eff[c_half-1:0]),
    .cin  (w_sub),
    .sum  (w_lo_sum),
    .cout (w_lo_carry)
  );

  adder_slice #(.W(c_half)) u_hi_slice (
    .a    (r_s1_hi_a),
    .b    (r_s1_hi_b),
    .cin  (r_s1_lo_carry),
    .sum  (w_hi_sum),
    .cout (w_carry)
  );

  assign w_full = {w_hi_sum, r_s1_lo_sum};
  assign w_ovf  = (r_s1_hi_a[c_half-1] == r_s1_hi_b[c_half-1]) &&
                  (w_full[WIDTH-1] != r_s1_hi_a[c_half-1]);

  always_comb begin
    w_result = w_full;
    case (r_s1_op)
      ALU_ADDW, ALU_SUBW: begin
        if (WORD_OPS != 0) begin
          w_result = {{c_half{w_full[c_half-1]}}, w_full[c_half-1:0]};
        end
      end
      ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_full[WIDTH-1] ^ w_ovf};
      ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, ~w_carry};
      default:  w_result = w_full;
    endcase
  end

  // S1 may refill whenever it is empty or its content moves on this cycle.
  assign w_advance = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_advance;
  assign in_ready  = !rst && w_s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= '0;
      r_s1_tag      <= '0;
      r_s1_hi_a     <= '0;
      r_s1_hi_b     <= '0;
      r_s1_lo_sum   <= '0;
      r_s1_lo_carry <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_tag     <= '0;
      r_out_carry   <= 1'b0;
      r_out_ovf     <= 1'b0;
      r_out_zero    <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_op       <= in_op;
          r_s1_tag      <= in_tag;
          r_s1_hi_a     <= in_src1[WIDTH-1:c_half];
          r_s1_hi_b     <= w_b_eff[WIDTH-1:c_half];
          r_s1_lo_sum   <= w_lo_sum;
          r_s1_lo_carry <= w_lo_carry;
        end
      end
      if (w_advance) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_result <= w_result;
          r_out_tag    <= r_s1_tag;
          r_out_carry  <= w_carry;
          r_out_ovf    <= w_ovf;
          r_out_zero   <= (w_result == '0);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_carry  = r_out_carry;
  assign out_ovf    = r_out_ovf;
  assign out_zero   = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_pipe : directed self-checking bench for adder_pipe (64-bit)     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;

  int total = 0;
  int bad   = 0;

  adder_pipe #(.WIDTH(64), .TAG_W(5), .WORD_OPS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One op with out_ready held high; checks latency, result, tag and flags.
  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp_res,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_tag    = tag;
    #1;
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'd2);
    check({name, " result"}, out_result, exp_res);
    check({name, " tag"}, 64'(out_tag), 64'(tag));
    check({name, " carry"}, 64'(out_carry), 64'(exp_c));
    check({name, " ovf"}, 64'(out_ovf), 64'(exp_v));
    check({name, " zero"}, 64'(out_zero), 64'(exp_z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int rcv;
    int n;

    // Reset held with a request pending
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_op     = 4'd0;
    in_src1   = 64'd3;
    in_src2   = 64'd4;
    in_tag    = 5'd9;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd0);
    end
    check("rst out_result", out_result, 64'd0);
    check("rst out_tag", 64'(out_tag), 64'd0);
    check("rst flags", 64'({out_carry, out_ovf, out_zero}), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-rst no output", 64'(out_valid), 64'd0);
    end

    // Directed arithmetic
    run_op("add wrap", 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 64'd0, 1'b1, 1'b0, 1'b1);
    run_op("sub ovf", 4'd1, 64'h8000_0000_0000_0000, 64'd1, 5'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("slt -1<1", 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd2, 64'd1, 1'b1, 1'b0, 1'b0);
    run_op("sltu -1<1", 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd0, 1'b1, 1'b0, 1'b1);
    run_op("slt 1<-1", 4'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd0, 1'b0, 1'b0, 1'b1);
    run_op("sltu 1<-1", 4'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd1, 1'b0, 1'b0, 1'b0);
    run_op("addw sext", 4'd2, 64'h0000_0000_7FFF_FFFF, 64'd1, 5'd6,
           64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("subw 0-1", 4'd3, 64'd0, 64'd1, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("add half carry", 4'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd9,
           64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("add pos ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd10,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    step();

    // Back-pressure: out_ready low during stream cycles 3..6
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 6);
      in_op     = 4'd0;
      in_src1   = 64'(sent);
      in_src2   = 64'(sent);
      in_tag    = 5'(sent);
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        check("bp in_ready held low", 64'(in_ready), 64'd0);
        check("bp ops accepted before stall", 64'(sent), 64'd3);
      end
      if (out_valid && out_ready) begin
        check("bp result", out_result, 64'(2 * rcv));
        check("bp tag", 64'(out_tag), 64'(rcv));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp all received", 64'(rcv), 64'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp no duplicate", 64'(out_valid), 64'd0);
    end

    // Reset with two ops in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'd0;
    in_src1   = 64'd100;
    in_src2   = 64'd1;
    in_tag    = 5'd20;
    step();
    in_tag = 5'd21;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    check("mid-rst out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    run_op("first after rst", 4'd0, 64'd5, 64'd6, 5'd12, 64'd11, 1'b0, 1'b0, 1'b0);

    // Undefined op codes behave as ADD
    for (int op = 6; op < 16; op++) begin
      run_op("undef op as add", 4'(op), 64'h0000_0001_0000_0003, 64'h0000_0002_FFFF_FFFE,
             5'(op), 64'h0000_0004_0000_0001, 1'b0, 1'b0, 1'b0);
    end
    step();
    n = 0;
    check("idle at end", 64'(out_valid), 64'(n));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
